// File: rtl/systolic_seq_ctrl.sv
// rtl/systolic_seq_ctrl.sv - tile sequencer feeding skewed operands into an N x N MAC array
module systolic_seq_ctrl #(
  parameter int N      = 2,
  parameter int DATA_W = 8,
  parameter int DRAIN  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  input  logic                       wr_en,
  input  logic                       wr_sel,
  input  logic [$clog2(N*N)-1:0]     wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       arr_clr,
  output logic [N*DATA_W-1:0]        a_edge,
  output logic [N*DATA_W-1:0]        b_edge,
  input  logic [N*N*DATA_W-1:0]      res_in,
  output logic [N*N*DATA_W-1:0]      res_out
);

  localparam int CW = $clog2(3*N + DRAIN);
  localparam logic [CW-1:0] FEED_LAST  = CW'(3*N - 3);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [DATA_W-1:0]   abuf [N*N];
  logic [DATA_W-1:0]   bbuf [N*N];
  logic [N*DATA_W-1:0] a_n, b_n;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = '0;
    b_n     = '0;
    case (state)
      S_IDLE:    if (start) state_n = S_CLEAR;
      S_CLEAR: begin
        state_n = S_FEED;
        cnt_n   = '0;
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) state_n = S_CAPTURE;
        else                   cnt_n   = cnt + 1'b1;
      end
      S_CAPTURE: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase

    // Edge values are prepared for the step about to start: row i/col j see element k at t = i + k / k + j.
    if (state_n == S_FEED) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (cnt_n == CW'(i + k)) begin
            a_n[i*DATA_W +: DATA_W] = abuf[i*N + k];
            b_n[i*DATA_W +: DATA_W] = bbuf[k*N + i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_edge  <= '0;
      b_edge  <= '0;
      res_out <= '0;
      arr_clr <= 1'b1;
      for (int e = 0; e < N*N; e++) begin
        abuf[e] <= '0;
        bbuf[e] <= '0;
      end
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_edge  <= a_n;
      b_edge  <= b_n;
      arr_clr <= (state_n == S_CLEAR);
      if (state_n == S_CAPTURE) res_out <= res_in;
      if (state == S_IDLE && wr_en) begin
        if (wr_sel) bbuf[wr_addr] <= wr_data;
        else        abuf[wr_addr] <= wr_data;
      end
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_CAPTURE);

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb/tb_systolic_seq_ctrl.sv - directed and random tile runs against a matrix-level model
module tb_systolic_seq_ctrl;
  localparam int N  = 2;
  localparam int DW = 8;
  localparam int DR = 2;
  localparam int AW = $clog2(N*N);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              wr_en = 1'b0;
  logic              wr_sel = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [N*N*DW-1:0] res_in = '0;
  logic              busy, done, arr_clr;
  logic [N*DW-1:0]   a_edge, b_edge;
  logic [N*N*DW-1:0] res_out;

  int n_assert = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int ma [N][N];
  int mb [N][N];
  logic [N*N*DW-1:0] res_exp = '0;

  systolic_seq_ctrl #(.N(N), .DATA_W(DW), .DRAIN(DR)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .arr_clr(arr_clr), .a_edge(a_edge), .b_edge(b_edge),
    .res_in(res_in), .res_out(res_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  function automatic logic [N*DW-1:0] exp_a(input int t);
    logic [N*DW-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[i*DW +: DW] = DW'(ma[i][t-i]);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] exp_b(input int t);
    logic [N*DW-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[j*DW +: DW] = DW'(mb[t-j][j]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic sel, input int addr, input int data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = DW'(data);
    tick();
    wr_en = 1'b0;
    if (sel) mb[addr/N][addr%N] = data;
    else     ma[addr/N][addr%N] = data;
  endtask

  task automatic load_random();
    for (int e = 0; e < N*N; e++) begin
      wr(1'b0, e, int'($urandom_range(0, 255)));
      wr(1'b1, e, int'($urandom_range(0, 255)));
    end
    res_in = {$urandom};
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    res_exp = '0;
  endtask

  // mode: 0 plain, 1 start/write injected during FEED, 2 write with start, 3 reset at FEED t1
  task automatic run_tile(input int mode);
    int d0 = done_cnt;
    start = 1'b1;
    if (mode == 2) begin
      wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'd9;
      ma[0][0] = 9;
    end
    for (int c = 1; c <= 3*N + DR + 1; c++) begin
      tick();
      start = 1'b0;
      wr_en = 1'b0;
      if (mode == 3 && c == 4) begin
        clear_model();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res_out", res_out, res_exp);
        chk("abort_arr_clr", arr_clr, 1);
        chk("abort_a_edge", a_edge, 0);
        rst = 1'b1;
        repeat (10) begin
          tick();
          chk("abort_idle_busy", busy, 0);
        end
        chk("abort_no_done", done_cnt, d0);
        return;
      end
      if (c == 3*N + DR) res_exp = res_in;
      chk("busy", busy, (c <= 3*N + DR) ? 1 : 0);
      chk("done", done, (c == 3*N + DR) ? 1 : 0);
      chk("arr_clr", arr_clr, (c == 1) ? 1 : 0);
      chk("a_edge", a_edge, (c >= 2 && c <= 3*N - 1) ? exp_a(c - 2) : '0);
      chk("b_edge", b_edge, (c >= 2 && c <= 3*N - 1) ? exp_b(c - 2) : '0);
      chk("res_out", res_out, res_exp);
      if (mode == 1 && c == 2) begin
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = '0; wr_data = 8'hFF;
      end
      if (mode == 3 && c == 3) rst = 1'b0;
    end
    chk("done_count", done_cnt, d0 + 1);
  endtask

  initial begin
    clear_model();
    rst = 1'b0;
    repeat (3) begin
      start = 1'($urandom); wr_en = 1'($urandom); wr_sel = 1'($urandom);
      wr_addr = AW'($urandom); wr_data = DW'($urandom); res_in = {$urandom};
      tick();
    end
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_a_edge", a_edge, 0);
    chk("rst_b_edge", b_edge, 0);
    chk("rst_res_out", res_out, 0);
    chk("rst_arr_clr", arr_clr, 1);
    rst = 1'b1; start = 1'b0; wr_en = 1'b0;
    tick();
    chk("post_rst_arr_clr", arr_clr, 0);
    chk("post_rst_busy", busy, 0);
    chk("rst_no_done", done_cnt, 0);

    for (int e = 0; e < N*N; e++) wr(1'b0, e, e + 1);
    for (int e = 0; e < N*N; e++) wr(1'b1, e, e + 5);
    res_in = 32'h1316_2B32;
    run_tile(0);
    chk("capture_value", res_out, 32'h1316_2B32);

    res_in = {$urandom};
    repeat (2) tick();
    chk("res_out_hold", res_out, res_exp);

    run_tile(1);
    run_tile(0);
    run_tile(2);

    load_random();
    run_tile(0);
    res_in = {$urandom};
    run_tile(0);
    repeat (3) begin
      load_random();
      run_tile(0);
    end

    run_tile(3);
    res_in = {$urandom};
    run_tile(0);
    load_random();
    run_tile(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
